// File: rtl/seq_mult_ctrl_pkg.sv
// seq_mult_ctrl_pkg: shared calculator types, count-width helper and default operand width
package seq_mult_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CALC_W = 4;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
  localparam int CNT_W = cnt_width(CALC_W);
endpackage

// File: rtl/seq_mult_ctrl_pp_gen.sv
// pp_gen: partial product = operand gated by one multiplier bit; ports opnd[W], sel, pp[W]
module pp_gen #(
  parameter int W = 4
) (
  input  logic [W-1:0] opnd,
  input  logic         sel,
  output logic [W-1:0] pp
);
  assign pp = opnd & {W{sel}};
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-add multiplier; ports clk, rst_n, start, a[W], b[W] -> busy, done, product[2W]
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = cnt_width(W);
  state_t state;
  logic [CW-1:0] count;
  logic [W-1:0] a_q, b_q, pp;
  logic [2*W-1:0] pp_ext;
  pp_gen #(.W(W)) u_pp (.opnd(a_q), .sel(b_q[count]), .pp(pp));
  assign pp_ext = {{W{1'b0}}, pp} << count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      count   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          a_q     <= a;
          b_q     <= b;
          product <= '0;
          count   <= '0;
          busy    <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          product <= product + pp_ext;
          count   <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: randomized and directed self-checking bench against an arithmetic reference
module tb_seq_mult_ctrl;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n, start;
  logic [W-1:0] a, b;
  logic busy, done;
  logic [2*W-1:0] product;
  int total = 0, bad = 0;

  seq_mult_ctrl #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // waits from the start edge until done; returns edges elapsed and busy samples seen
  task automatic wait_done(output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      tick();
      n++;
    end
    if (busy) busy_n++;
  endtask

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    int n, bn;
    a = x;
    b = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    wait_done(n, bn);
    check({tag, " latency"}, n, W);
    check({tag, " product"}, product, 32'(x) * 32'(y));
    check({tag, " busy cycles"}, bn, W + 1);
    tick();
    check({tag, " done drops"}, done, 0);
    check({tag, " busy drops"}, busy, 0);
    check({tag, " product held"}, product, 32'(x) * 32'(y));
  endtask

  initial begin
    int n, bn, dones;
    logic [2*W-1:0] held;
    logic [W-1:0] xs [7] = '{4'd6, 4'd15, 4'd0, 4'd9, 4'd1, 4'd5, 4'd12};
    logic [W-1:0] ys [7] = '{4'd7, 4'd15, 4'd9, 4'd0, 4'd15, 4'd3, 4'd10};
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset product", product, 0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_op(xs[i], ys[i], $sformatf("dir%0d", i));

    // asynchronous reset mid-run abandons the operation
    a = 4'd9;
    b = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre-reset busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async product", product, 0);
    tick();
    #2 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) dones++;
    end
    check("no done after reset", dones, 0);
    check("idle after reset", busy, 0);
    run_op(4'd3, 4'd3, "post-reset");

    // start pulses during RUN and DONE are ignored
    a = 4'd5;
    b = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd15;
    b = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bn);
    n += 2;
    check("ign latency", n, W);
    check("ign product", product, 15);
    start = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      check("ign busy", busy, 0);
      tick();
    end
    check("ign extra done", dones, 0);
    check("ign product kept", product, 15);

    // back-to-back with start held high and operands changed mid-op
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    tick();
    a = 4'd4;
    b = 4'd4;
    wait_done(n, bn);
    check("b2b1 latency", n, W);
    check("b2b1 product", product, 6);
    tick();
    check("b2b idle busy", busy, 0);
    tick();
    check("b2b2 accepted", busy, 1);
    start = 1'b0;
    wait_done(n, bn);
    check("b2b2 latency", n, W);
    check("b2b2 product", product, 16);
    tick();

    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom_range(0, 15));
      y = W'($urandom_range(0, 15));
      run_op(x, y, $sformatf("rnd%0d", i));
    end

    // hold: product stays put while idle
    held = product;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold product", product, 32'(held));
      check("hold busy", busy, 0);
      check("hold done", done, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
